voice_mixer: RTL and testbench
==============================

Name: voice_mixer

Overview:
- Downstream stage of the four-voice sine generator. Takes its four signed voice outputs and mixes them into one saturated signed sample for the I2S transmitter.
- Each voice has its own unsigned gain. One multiplier is time-shared across the voices, stepped by a small FSM.
- One mix is started per audio sample by a single-cycle `start` strobe, derived from the LR clock edge upstream.

Parameters:
- BITSIZE, 24, width of voice inputs and mixed output (signed two's complement)
- GAINSIZE, 8, width of each unsigned gain
- GAINFRAC, 7, fractional bits of gain; unity = 2**GAINFRAC (128)

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to mix one sample
- in_1..in_4  input  BITSIZE each  signed voice samples
- gain_1..gain_4  input  GAINSIZE each  unsigned gain, Q(GAINSIZE-GAINFRAC).GAINFRAC
- out  output  BITSIZE  signed mixed sample, held until next result
- out_valid  output  1  one-cycle pulse when `out` updates
- busy  output  1  high while a mix is in progress
- clipped  output  1  registered with `out`: 1 if that result was saturated
- overrun  output  1  one-cycle pulse when `start` arrives while busy

Behaviour:
- Reset is asynchronous and active-high. All outputs, the accumulator and the snapshots go to 0, and the FSM goes to IDLE.
- Reset asserted mid-mix aborts the mix with no out_valid. The first `start` after reset release is accepted normally.
- FSM states: IDLE, MAC, SAT.
- IDLE:
  - On an edge with start=1 (edge E0), snapshot in_1..4 and gain_1..4, clear the accumulator, set ch=0, set busy=1, go to MAC.
  - Later input changes do not affect the result being computed.
- MAC (edges E1..E4):
  - acc += sext(in_snap[ch]) * zext(gain_snap[ch]); ch increments 0..3.
  - After ch=3, go to SAT.
- SAT (edge E5):
  - r = acc >>> GAINFRAC (arithmetic shift, rounds toward -inf).
  - If r > 2**(BITSIZE-1)-1, out = max and clipped = 1.
  - Else if r < -2**(BITSIZE-1), out = min and clipped = 1.
  - Otherwise out = r[BITSIZE-1:0] and clipped = 0.
  - Set out_valid=1 and busy=0, go to IDLE.
- out_valid drops at E6.
- Latency: result and out_valid are visible after E5, i.e. 5 clocks after the start edge.
- A new start is accepted at E6 or later, giving a minimum spacing of 6 clocks.
- Accumulator width: BITSIZE+GAINSIZE+3. It holds 4 full-scale products plus sign without overflow.
- A start seen in MAC, or at the SAT edge, is ignored and produces an overrun pulse on the next cycle. The current mix is unaffected.
- A gain of 0 mutes that voice exactly.
- `out` and `clipped` hold their values between results.
- There is no combinational path from any input to any output.

Decomposition:
- Shared package (audio_mix_pkg) holds:
  - state encoding (IDLE/MAC/SAT)
  - GAIN_UNITY constant
  - accumulator-width constant
  - a pure saturate function (wide signed -> BITSIZE signed, plus a clip flag), reusable by later effect stages
- No sub-module needed. The single multiplier and the FSM stay in voice_mixer.

Test Plan (BITSIZE=24, GAINSIZE=8, GAINFRAC=7):
- Single voice at unity:
  - Stimulus: in_1=1000, gain_1=128, other gains 0, start pulse.
  - Response: out=1000, clipped=0, out_valid exactly 5 clocks after start, busy high for 5 clocks.
- Cancellation and rounding:
  - Stimulus A: in_1=1000/gain 128, in_2=-500/gain 128.
  - Response A: out=500.
  - Stimulus B (separate run): in_1=-3, gain_1=64.
  - Response B: out=-2 (floor rounding).
- Saturation:
  - Stimulus: all in=0x7FFFFF, all gains 255.
  - Response: out=0x7FFFFF, clipped=1.
  - Stimulus: all in=0x800000, all gains 255.
  - Response: out=0x800000, clipped=1.
- Snapshot and overrun:
  - Stimulus: start with in_1=100/gain 128; change in_1 to 9999 at E1; pulse start again at E2.
  - Response: out=100, one out_valid only, one overrun pulse.
  - Stimulus: start again at E6.
  - Response: accepted, out=9999.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously at E3.
  - Response: out=0, out_valid=0, busy=0, clipped=0 immediately; no pulse follows.
  - Stimulus: after release, start with in_4=-7000/gain 128.
  - Response: out=-7000.
- Back-to-back throughput:
  - Stimulus: 10 starts spaced 6 clocks apart with random in/gain.
  - Response: 10 results matching a reference model, zero overrun.

Source files
------------

// File: rtl/audio_mix_pkg.sv
// Shared definitions for the audio mixing and effect stages: FSM encoding,
// gain/accumulator constants and a reusable saturating narrowing function.
package audio_mix_pkg;

    localparam int GAINFRAC_DEF = 7;
    localparam int GAIN_UNITY   = 1 << GAINFRAC_DEF;
    localparam int ACC_HEADROOM = 3;
    localparam int ACC_W        = 24 + 8 + ACC_HEADROOM;
    localparam int SAT_W        = 64;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SAT
    } mix_state_t;

    typedef struct packed {
        logic signed [SAT_W-1:0] value;
        logic                    clip;
    } sat_result_t;

    // Clamps a wide signed value into a signed range of 'bits' bits.
    function automatic sat_result_t saturate(input logic signed [SAT_W-1:0] value,
                                             input int bits);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sat_result_t res;
        max_v = (64'sd1 <<< (bits - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        res.value = value;
        res.clip  = 1'b0;
        if (value > max_v) begin
            res.value = max_v;
            res.clip  = 1'b1;
        end else if (value < min_v) begin
            res.value = min_v;
            res.clip  = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/voice_mixer.sv
// Four-voice gain mixer: one time-shared multiplier walks the voice snapshots,
// then the accumulated sum is rescaled and saturated into a single sample.
module voice_mixer
    import audio_mix_pkg::*;
#(
    parameter int BITSIZE  = 24,
    parameter int GAINSIZE = 8,
    parameter int GAINFRAC = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic signed [BITSIZE-1:0]  in_1,
    input  logic signed [BITSIZE-1:0]  in_2,
    input  logic signed [BITSIZE-1:0]  in_3,
    input  logic signed [BITSIZE-1:0]  in_4,
    input  logic        [GAINSIZE-1:0] gain_1,
    input  logic        [GAINSIZE-1:0] gain_2,
    input  logic        [GAINSIZE-1:0] gain_3,
    input  logic        [GAINSIZE-1:0] gain_4,
    output logic signed [BITSIZE-1:0]  out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       clipped,
    output logic                       overrun
);

    localparam int ACCW  = BITSIZE + GAINSIZE + ACC_HEADROOM;
    localparam int PRODW = BITSIZE + GAINSIZE + 1;

    mix_state_t state;
    mix_state_t state_next;

    logic        [1:0]          ch;
    logic signed [BITSIZE-1:0]  in_snap   [4];
    logic        [GAINSIZE-1:0] gain_snap [4];
    logic signed [ACCW-1:0]     acc;
    logic signed [PRODW-1:0]    product;
    logic signed [ACCW-1:0]     acc_shift;
    sat_result_t                sat;
    logic                       load;
    logic                       mac_en;
    logic                       sat_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = MAC;
            MAC:     if (ch == 2'd3) state_next = SAT;
            SAT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        load   = (state == IDLE) && start;
        mac_en = (state == MAC);
        sat_en = (state == SAT);
    end

    // Gain is zero-extended so it multiplies as a non-negative signed operand.
    assign product   = PRODW'(in_snap[ch]) * PRODW'($signed({1'b0, gain_snap[ch]}));
    assign acc_shift = acc >>> GAINFRAC;
    assign sat       = saturate(SAT_W'(acc_shift), BITSIZE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                in_snap[i]   <= '0;
                gain_snap[i] <= '0;
            end
            acc       <= '0;
            ch        <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            clipped   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= sat_en;
            overrun   <= start && busy;
            if (load) begin
                in_snap[0]   <= in_1;
                in_snap[1]   <= in_2;
                in_snap[2]   <= in_3;
                in_snap[3]   <= in_4;
                gain_snap[0] <= gain_1;
                gain_snap[1] <= gain_2;
                gain_snap[2] <= gain_3;
                gain_snap[3] <= gain_4;
                acc          <= '0;
                ch           <= '0;
            end
            if (mac_en) begin
                acc <= acc + ACCW'(product);
                ch  <= ch + 2'd1;
            end
            if (sat_en) begin
                out     <= sat.value[BITSIZE-1:0];
                clipped <= sat.clip;
            end
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// Scoreboard bench for voice_mixer: stimulus pushes expected results, a
// negedge monitor pops and compares them whenever out_valid pulses.
module tb_voice_mixer;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic signed [23:0] in_1 = '0;
    logic signed [23:0] in_2 = '0;
    logic signed [23:0] in_3 = '0;
    logic signed [23:0] in_4 = '0;
    logic        [7:0]  gain_1 = '0;
    logic        [7:0]  gain_2 = '0;
    logic        [7:0]  gain_3 = '0;
    logic        [7:0]  gain_4 = '0;
    logic signed [23:0] out;
    logic               out_valid;
    logic               busy;
    logic               clipped;
    logic               overrun;

    typedef struct {
        string name;
        int    outExp;
        bit    clipExp;
        int    startCycle;
    } exp_t;

    exp_t sbQueue[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   validCount = 0;
    int   overrunCount = 0;

    voice_mixer #(.BITSIZE(24), .GAINSIZE(8), .GAINFRAC(7)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_1(in_1), .in_2(in_2), .in_3(in_3), .in_4(in_4),
        .gain_1(gain_1), .gain_2(gain_2), .gain_3(gain_3), .gain_4(gain_4),
        .out(out), .out_valid(out_valid), .busy(busy),
        .clipped(clipped), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (overrun) overrunCount++;
        if (out_valid) begin
            validCount++;
            if (sbQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got out=%0d, expected no result", int'(out));
            end else begin
                e = sbQueue.pop_front();
                checkOutput({e.name, "_out"}, int'(out), e.outExp);
                checkOutput({e.name, "_clip"}, int'(clipped), int'(e.clipExp));
                checkOutput({e.name, "_latency"}, cycle - e.startCycle, 5);
            end
        end
    end

    // Called at a negedge; start is sampled on the following rising edge.
    task automatic applyStimulus(input string name,
                                 input int i1, input int i2, input int i3, input int i4,
                                 input int g1, input int g2, input int g3, input int g4,
                                 input bit doExpect, input int outExp, input bit clipExp);
        exp_t e;
        in_1 = 24'(i1); in_2 = 24'(i2); in_3 = 24'(i3); in_4 = 24'(i4);
        gain_1 = 8'(g1); gain_2 = 8'(g2); gain_3 = 8'(g3); gain_4 = 8'(g4);
        start = 1'b1;
        if (doExpect) begin
            e.name = name;
            e.outExp = outExp;
            e.clipExp = clipExp;
            e.startCycle = cycle + 1;
            sbQueue.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sbQueue.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sbQueue.size());
        end
        @(negedge clk);
    endtask

    function automatic void refMix(input int i1, input int i2, input int i3, input int i4,
                                   input int g1, input int g2, input int g3, input int g4,
                                   output int o, output bit c);
        longint acc;
        longint r;
        acc = longint'(i1) * g1 + longint'(i2) * g2 + longint'(i3) * g3 + longint'(i4) * g4;
        r = acc >>> 7;
        c = 1'b1;
        if (r > 64'sd8388607) o = 8388607;
        else if (r < -64'sd8388608) o = -8388608;
        else begin
            o = int'(r);
            c = 1'b0;
        end
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busyCycles;
        int ov0;
        int v0;
        int v[4];
        int g[4];
        int expOut;
        bit expClip;
        logic signed [23:0] rs;

        #1;
        checkOutput("reset_out", int'(out), 0);
        checkOutput("reset_valid", int'(out_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_clipped", int'(clipped), 0);
        checkOutput("reset_overrun", int'(overrun), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single voice at unity; voice 2 carries signal but is muted by gain 0.
        applyStimulus("unity", 1000, 12345, 0, 0, 128, 0, 0, 0, 1'b1, 1000, 1'b0);
        busyCycles = 0;
        for (int i = 0; i < 7; i++) begin
            if (busy) busyCycles++;
            @(negedge clk);
        end
        checkOutput("busy_cycles", busyCycles, 5);
        waitDrain();

        applyStimulus("cancel", 1000, -500, 0, 0, 128, 128, 0, 0, 1'b1, 500, 1'b0);
        waitDrain();
        applyStimulus("floor", -3, 0, 0, 0, 64, 0, 0, 0, 1'b1, -2, 1'b0);
        waitDrain();

        // Snapshot isolation plus an overrun start at E2 and a legal start at E6.
        ov0 = overrunCount;
        v0 = validCount;
        applyStimulus("snap", 100, 0, 0, 0, 128, 0, 0, 0, 1'b1, 100, 1'b0);
        in_1 = 24'sd9999;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus("snap_next", 9999, 0, 0, 0, 128, 0, 0, 0, 1'b1, 9999, 1'b0);
        waitDrain();
        checkOutput("snap_overruns", overrunCount - ov0, 1);
        checkOutput("snap_valids", validCount - v0, 2);

        applyStimulus("sat_max", 8388607, 8388607, 8388607, 8388607,
                      255, 255, 255, 255, 1'b1, 8388607, 1'b1);
        waitDrain();
        applyStimulus("sat_min", -8388608, -8388608, -8388608, -8388608,
                      255, 255, 255, 255, 1'b1, -8388608, 1'b1);
        waitDrain();

        // Abort a mix with reset just after E3.
        v0 = validCount;
        applyStimulus("aborted", 50, 0, 0, 0, 128, 0, 0, 0, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("abort_out", int'(out), 0);
        checkOutput("abort_valid", int'(out_valid), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_clipped", int'(clipped), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("abort_no_pulse", validCount - v0, 0);
        checkOutput("abort_out_hold", int'(out), 0);
        applyStimulus("after_reset", 0, 0, 0, -7000, 0, 0, 0, 128, 1'b1, -7000, 1'b0);
        waitDrain();

        // Back-to-back mixes at the minimum six-clock spacing.
        ov0 = overrunCount;
        v0 = validCount;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 1) == 1) begin
                    rs = 24'($urandom);
                    v[j] = int'(rs);
                end else begin
                    v[j] = int'($urandom_range(0, 400000)) - 200000;
                end
                g[j] = int'($urandom_range(0, 255));
            end
            refMix(v[0], v[1], v[2], v[3], g[0], g[1], g[2], g[3], expOut, expClip);
            applyStimulus($sformatf("b2b%0d", i), v[0], v[1], v[2], v[3],
                          g[0], g[1], g[2], g[3], 1'b1, expOut, expClip);
            repeat (5) @(negedge clk);
        end
        waitDrain();
        checkOutput("b2b_overruns", overrunCount - ov0, 0);
        checkOutput("b2b_valids", validCount - v0, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
